// File: rtl/cla_seq_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : cla_seq_pkg
//  Description : Shared types and constants for the sequential CLA adder.
//                Holds the controller state encoding, the nibble width and
//                a helper that sizes the nibble index counter.
//  Revision    : 1.0 - initial release
// ============================================================================
package cla_seq_pkg;

    // Width of the single carry-lookahead slice that is reused every cycle.
    localparam int NIB_W = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Bits needed to count nibble steps 0..NIB-1; never narrower than 1.
    function automatic int nib_bits(input int width);
        int nib;
        nib = width / NIB_W;
        return (nib <= 1) ? 1 : $clog2(nib);
    endfunction

endpackage
`default_nettype wire

// File: rtl/cla_seq_adder_cla4.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : cla_seq_adder_cla4
//  Description : Purely combinational 4-bit carry-lookahead adder slice.
//  Ports       : i_a, i_b  - nibble operands
//                i_cin     - carry in
//                o_sum     - nibble sum
//                o_cout    - carry out of bit 3
//  Revision    : 1.0 - initial release
// ============================================================================
module cla_seq_adder_cla4
    import cla_seq_pkg::*;
(
    input  logic [NIB_W-1:0] i_a,
    input  logic [NIB_W-1:0] i_b,
    input  logic             i_cin,
    output logic [NIB_W-1:0] o_sum,
    output logic             o_cout
);

    logic [NIB_W-1:0] w_g;
    logic [NIB_W-1:0] w_p;
    logic [NIB_W:0]   w_c;

    assign w_g = i_a & i_b;
    assign w_p = i_a ^ i_b;

    // Every carry is flattened to two logic levels from g/p and cin.
    assign w_c[0] = i_cin;
    assign w_c[1] = w_g[0] | (w_p[0] & w_c[0]);
    assign w_c[2] = w_g[1] | (w_p[1] & w_g[0]) | (w_p[1] & w_p[0] & w_c[0]);
    assign w_c[3] = w_g[2] | (w_p[2] & w_g[1]) | (w_p[2] & w_p[1] & w_g[0])
                  | (w_p[2] & w_p[1] & w_p[0] & w_c[0]);
    assign w_c[4] = w_g[3] | (w_p[3] & w_g[2]) | (w_p[3] & w_p[2] & w_g[1])
                  | (w_p[3] & w_p[2] & w_p[1] & w_g[0])
                  | (w_p[3] & w_p[2] & w_p[1] & w_p[0] & w_c[0]);

    assign o_sum  = w_p ^ w_c[NIB_W-1:0];
    assign o_cout = w_c[NIB_W];

endmodule
`default_nettype wire

// File: rtl/cla_seq_adder.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : cla_seq_adder
//  Description : Wide adder that walks one 4-bit CLA slice across a WIDTH-bit
//                operand pair, LSB nibble first, one nibble per clock, with
//                the carry chained through a register.
//  Ports       : clk, rst           - clock, async active-high reset
//                in_valid/in_ready  - operand handshake (a, b, cin[, sub])
//                out_valid/out_ready- result handshake (sum, cout, ovf)
//                busy               - high while RUN or DONE
//  Options     : CLA_SEQ_SUB_EN adds the 'sub' port (A - B when sub=1).
//  Revision    : 1.0 - initial release
// ============================================================================
module cla_seq_adder
    import cla_seq_pkg::*;
#(
    parameter int WIDTH = 16   // multiple of 4, at least 4
)
(
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
`ifdef CLA_SEQ_SUB_EN
    input  logic             sub,
`endif
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf,
    output logic             busy
);

    localparam int                  NIB      = WIDTH / NIB_W;
    localparam int                  NIB_BITS = nib_bits(WIDTH);
    localparam logic [NIB_BITS-1:0] LAST_IDX = NIB_BITS'(NIB - 1);

    state_t              state_q, state_d;
    logic [NIB_BITS-1:0] idx_q,   idx_d;
    logic [WIDTH-1:0]    a_q,     a_d;
    logic [WIDTH-1:0]    b_q,     b_d;
    logic [WIDTH-1:0]    sum_q,   sum_d;
    logic                carry_q, carry_d;

    logic [WIDTH-1:0]    w_b_eff;
    logic                w_c0;
    logic [NIB_W-1:0]    w_slice_a;
    logic [NIB_W-1:0]    w_slice_b;
    logic [NIB_W-1:0]    w_slice_sum;
    logic                w_slice_cout;

    // Subtraction is A + ~B + 1, so only the latched B and first carry change.
`ifdef CLA_SEQ_SUB_EN
    assign w_b_eff = sub ? ~b   : b;
    assign w_c0    = sub ? 1'b1 : cin;
`else
    assign w_b_eff = b;
    assign w_c0    = cin;
`endif

    // Slice operands come straight from registers: one CLA delay per cycle.
    assign w_slice_a = a_q[idx_q * NIB_W +: NIB_W];
    assign w_slice_b = b_q[idx_q * NIB_W +: NIB_W];

    cla_seq_adder_cla4 u_cla4 (
        .i_a    (w_slice_a),
        .i_b    (w_slice_b),
        .i_cin  (carry_q),
        .o_sum  (w_slice_sum),
        .o_cout (w_slice_cout)
    );

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        a_d     = a_q;
        b_d     = b_q;
        sum_d   = sum_q;
        carry_d = carry_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    a_d     = a;
                    b_d     = w_b_eff;
                    carry_d = w_c0;
                    idx_d   = '0;
                    sum_d   = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                sum_d[idx_q * NIB_W +: NIB_W] = w_slice_sum;
                carry_d = w_slice_cout;
                if (idx_q == LAST_IDX) begin
                    idx_d   = '0;
                    state_d = DONE;
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            idx_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            carry_q <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sum_q   <= sum_d;
            carry_q <= carry_d;
        end
    end

    // Reset gates in_ready so nothing looks acceptable while rst is held.
    assign in_ready  = (state_q == IDLE) & ~rst;
    assign out_valid = (state_q == DONE);
    assign busy      = (state_q != IDLE);
    assign sum       = sum_q;
    assign cout      = carry_q;
    // Signed overflow: like-signed operands producing an opposite-signed sum.
    assign ovf       = (a_q[WIDTH-1] == b_q[WIDTH-1]) &
                       (sum_q[WIDTH-1] != a_q[WIDTH-1]);

endmodule
`default_nettype wire

// File: tb/tb_cla_seq_adder.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : tb_cla_seq_adder
//  Description : Self-checking bench for cla_seq_adder (WIDTH=16).
//                Directed vector table, handshake/reset corner sequences,
//                random operands and a back-to-back streaming run, all
//                compared against an arithmetic reference model.
//  Options     : CLA_SEQ_SUB_EN enables the subtraction vectors.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_cla_seq_adder;

    localparam int WIDTH = 16;
    localparam int NIB   = WIDTH / 4;

    logic             clk = 1'b0;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             sub;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             ovf;
    logic             busy;

    int checks = 0;
    int errors = 0;

    cla_seq_adder #(.WIDTH(WIDTH)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .cin       (cin),
`ifdef CLA_SEQ_SUB_EN
        .sub       (sub),
`endif
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .cout      (cout),
        .ovf       (ovf),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", nm, act, exp);
        end
    endtask

    // Reference: plain integer add of A, effective B and first carry.
    function automatic logic [WIDTH+1:0] model(input logic [WIDTH-1:0] ma,
                                               input logic [WIDTH-1:0] mb,
                                               input logic mc, input logic ms);
        logic [WIDTH-1:0] be;
        logic             c0;
        logic [WIDTH:0]   t;
        logic             o;
        be = ms ? ~mb : mb;
        c0 = ms ? 1'b1 : mc;
        t  = {1'b0, ma} + {1'b0, be} + {{WIDTH{1'b0}}, c0};
        o  = (ma[WIDTH-1] == be[WIDTH-1]) && (t[WIDTH-1] != ma[WIDTH-1]);
        return {o, t};
    endfunction

    // Caller is at a negedge with the block idle; returns at the negedge after accept.
    task automatic start_op(input logic [WIDTH-1:0] ta, input logic [WIDTH-1:0] tb,
                            input logic tc, input logic ts);
        a = ta; b = tb; cin = tc; sub = ts; in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    // Counts negedges after the accept edge until out_valid (bounded).
    task automatic wait_valid(output int lat);
        lat = 0;
        while (!out_valid && lat < 20) begin
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic do_op(input logic [WIDTH-1:0] ta, input logic [WIDTH-1:0] tb,
                         input logic tc, input logic ts,
                         input logic [WIDTH-1:0] es, input logic ec, input logic eo,
                         input string nm);
        int lat;
        @(negedge clk);
        out_ready = 1'b0;
        chk({nm, " in_ready"}, 32'(in_ready), 32'd1);
        start_op(ta, tb, tc, ts);
        chk({nm, " busy"}, 32'(busy), 32'd1);
        wait_valid(lat);
        chk({nm, " latency"}, 32'(lat), 32'(NIB));
        chk({nm, " sum"}, 32'(sum), 32'(es));
        chk({nm, " cout"}, 32'(cout), 32'(ec));
        chk({nm, " ovf"}, 32'(ovf), 32'(eo));
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_ready = 1'b0;
        chk({nm, " out_valid drop"}, 32'(out_valid), 32'd0);
    endtask

    typedef struct {
        logic [WIDTH-1:0] va;
        logic [WIDTH-1:0] vb;
        logic             vc;
        logic [WIDTH-1:0] es;
        logic             ec;
        logic             eo;
    } vec_t;

    initial begin
        vec_t             vt[7];
        logic [WIDTH+1:0] e;
        logic [WIDTH-1:0] ra, rb;
        logic             rc, rs;
        int               lat;
        logic [WIDTH+1:0] q[$];
        int               last_acc, n_acc, n_res;

        vt[0] = '{16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0, 1'b0};
        vt[1] = '{16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0};
        vt[2] = '{16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1};
        vt[3] = '{16'h0F0F, 16'h00F1, 1'b0, 16'h1000, 1'b0, 1'b0};
        vt[4] = '{16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 1'b1};
        vt[5] = '{16'h0000, 16'h0000, 1'b1, 16'h0001, 1'b0, 1'b0};
        vt[6] = '{16'hFFFF, 16'hFFFF, 1'b1, 16'hFFFF, 1'b1, 1'b0};

        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        a = '0; b = '0; cin = 1'b0; sub = 1'b0;

        // Reset values while rst is held
        @(negedge clk);
        @(negedge clk);
        chk("rst in_ready", 32'(in_ready), 32'd0);
        chk("rst out_valid", 32'(out_valid), 32'd0);
        chk("rst sum", 32'(sum), 32'd0);
        chk("rst cout", 32'(cout), 32'd0);
        chk("rst ovf", 32'(ovf), 32'd0);
        chk("rst busy", 32'(busy), 32'd0);
        rst = 1'b0;
        #1;
        chk("post-rst in_ready", 32'(in_ready), 32'd1);

        // Directed table
        for (int i = 0; i < 7; i++) begin
            do_op(vt[i].va, vt[i].vb, vt[i].vc, 1'b0,
                  vt[i].es, vt[i].ec, vt[i].eo, $sformatf("vec%0d", i));
        end

`ifdef CLA_SEQ_SUB_EN
        do_op(16'h0005, 16'h0007, 1'b0, 1'b1, 16'hFFFE, 1'b0, 1'b0, "sub5-7");
        do_op(16'h8000, 16'h0001, 1'b1, 1'b1, 16'h7FFF, 1'b1, 1'b1, "sub8000-1");
`endif

        // Result held under back-pressure while new operands are offered
        @(negedge clk);
        start_op(16'h7FFF, 16'h0001, 1'b0, 1'b0);
        wait_valid(lat);
        chk("hold latency", 32'(lat), 32'(NIB));
        for (int i = 0; i < 6; i++) begin
            a = 16'($urandom); b = 16'($urandom); cin = 1'($urandom); in_valid = i[0];
            #1;
            chk("hold in_ready", 32'(in_ready), 32'd0);
            chk("hold out_valid", 32'(out_valid), 32'd1);
            chk("hold sum", 32'(sum), 32'h8000);
            chk("hold cout/ovf", {30'd0, cout, ovf}, 32'd1);
            @(negedge clk);
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_ready = 1'b0;
        chk("hold release in_ready", 32'(in_ready), 32'd1);
        chk("hold release out_valid", 32'(out_valid), 32'd0);
        start_op(16'h1111, 16'h2222, 1'b1, 1'b0);
        wait_valid(lat);
        chk("after-hold latency", 32'(lat), 32'(NIB));
        chk("after-hold sum", 32'(sum), 32'h3334);
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_ready = 1'b0;

        // Reset two cycles into RUN discards the operation
        start_op(16'hAAAA, 16'h5555, 1'b1, 1'b0);
        @(posedge clk);
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        chk("midrst out_valid", 32'(out_valid), 32'd0);
        chk("midrst busy", 32'(busy), 32'd0);
        chk("midrst sum", 32'(sum), 32'd0);
        chk("midrst in_ready", 32'(in_ready), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("midrst release in_ready", 32'(in_ready), 32'd1);
        do_op(16'h0F0F, 16'h00F1, 1'b0, 1'b0, 16'h1000, 1'b0, 1'b0, "post-midrst");

        // Random operands against the model
        for (int i = 0; i < 25; i++) begin
            ra = 16'($urandom); rb = 16'($urandom); rc = 1'($urandom);
`ifdef CLA_SEQ_SUB_EN
            rs = 1'($urandom);
`else
            rs = 1'b0;
`endif
            e = model(ra, rb, rc, rs);
            do_op(ra, rb, rc, rs, e[WIDTH-1:0], e[WIDTH], e[WIDTH+1],
                  $sformatf("rand%0d", i));
        end

        // Streaming with both valid and ready held high: one IDLE cycle,
        // NIB RUN cycles and one DONE cycle per operation.
        @(negedge clk);
        in_valid = 1'b1; out_ready = 1'b1;
        last_acc = -1; n_acc = 0; n_res = 0;
        for (int cyc = 0; cyc < 60; cyc++) begin
            a = 16'($urandom); b = 16'($urandom); cin = 1'($urandom);
`ifdef CLA_SEQ_SUB_EN
            sub = 1'($urandom);
`endif
            if (out_valid) begin
                if (q.size() == 0) begin
                    chk("b2b spurious result", 32'd1, 32'd0);
                end else begin
                    e = q.pop_front();
                    n_res++;
                    chk("b2b sum", 32'(sum), 32'(e[WIDTH-1:0]));
                    chk("b2b cout/ovf", {30'd0, cout, ovf}, {30'd0, e[WIDTH], e[WIDTH+1]});
                end
            end
            if (in_ready) begin
                q.push_back(model(a, b, cin, sub));
                n_acc++;
                if (last_acc >= 0) chk("b2b interval", 32'(cyc - last_acc), 32'(NIB + 2));
                last_acc = cyc;
            end
            @(negedge clk);
        end
        in_valid = 1'b0;
        for (int i = 0; i < 15 && q.size() != 0; i++) begin
            if (out_valid) begin
                e = q.pop_front();
                n_res++;
                chk("drain sum", 32'(sum), 32'(e[WIDTH-1:0]));
            end
            @(negedge clk);
        end
        chk("b2b queue empty", 32'(q.size()), 32'd0);
        chk("b2b results==accepts", 32'(n_res), 32'(n_acc));
        chk("b2b accept count", 32'(n_acc >= 10), 32'd1);
        out_ready = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
